// File: rtl/seg_capture_pkg.sv
// Shared definitions for seg_mux_capture: active-low glyph constants, tracker
// state/struct types and the per-channel tracker step and commit functions.
package seg_capture_pkg;

  localparam int CNT_W = 4;

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index is the nibble value; bit6=g .. bit0=a, a segment is lit when 0.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    TRK_IDLE   = 2'd0,
    TRK_TRACK  = 2'd1,
    TRK_LOCKED = 2'd2
  } trk_state_t;

  typedef struct packed {
    trk_state_t       state;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
  } trk_t;

  function automatic trk_t trk_next(input trk_t cur, input logic sel, input logic legal,
                                    input logic [3:0] val, input logic [CNT_W-1:0] stable);
    trk_t nxt;
    nxt = cur;
    if (sel) begin
      if (!legal) begin
        nxt.state = TRK_IDLE;
        nxt.cnt   = '0;
      end else begin
        case (cur.state)
          TRK_IDLE: begin
            nxt.state = TRK_TRACK;
            nxt.cand  = val;
            nxt.cnt   = CNT_W'(1);
          end
          TRK_TRACK: begin
            if (val == cur.cand) begin
              if (cur.cnt + CNT_W'(1) >= stable) begin
                nxt.state = TRK_LOCKED;
                nxt.cnt   = stable;
              end else begin
                nxt.cnt = cur.cnt + CNT_W'(1);
              end
            end else begin
              nxt.cand = val;
              nxt.cnt  = CNT_W'(1);
            end
          end
          TRK_LOCKED: begin
            if (val != cur.cand) begin
              nxt.state = TRK_TRACK;
              nxt.cand  = val;
              nxt.cnt   = CNT_W'(1);
            end
          end
          default: begin
            nxt.state = TRK_IDLE;
            nxt.cnt   = '0;
          end
        endcase
      end
    end
    return nxt;
  endfunction

  // True on the sample that carries a tracking channel to its stable count.
  function automatic logic trk_commit(input trk_t cur, input logic sel, input logic legal,
                                      input logic [3:0] val, input logic [CNT_W-1:0] stable);
    return sel && legal && (cur.state == TRK_TRACK) && (val == cur.cand) &&
           (cur.cnt + CNT_W'(1) >= stable);
  endfunction

endpackage

// File: rtl/seg7_inv_decode.sv
// Combinational decoder for one active-low 7-segment pattern; legal flags a
// hex glyph (0-9, A-F), is_minus/is_blank flag the two sign-digit patterns.
module seg7_inv_decode
  import seg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       is_minus,
  output logic       is_blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

  assign is_minus = (seg == SEG_MINUS);
  assign is_blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seg_mux_capture.sv
// Recovers a signed hex digit from a multiplexed active-low display bus.
// Optional sticky illegal-pattern flag: define SEG_MUX_CAPTURE_ERR_EN.
module seg_mux_capture
  import seg_capture_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       an3_in,
  input  logic       an4_in,
  output logic [3:0] mag,
  output logic       neg,
  output logic       upd,
  output logic       err
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

  logic [6:0] seg_q;
  logic       an3_q, an4_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 7'b1111111;
      an3_q <= 1'b1;
      an4_q <= 1'b1;
    end else begin
      seg_q <= seg_in;
      an3_q <= an3_in;
      an4_q <= an4_in;
    end
  end

  // Both anodes low or both high is a blanking/overlap cycle and is ignored.
  logic sel_sgn, sel_mag;
  assign sel_sgn = !an3_q && an4_q;
  assign sel_mag = an3_q && !an4_q;

  logic       s_legal, s_minus, s_blank;
  logic [3:0] s_nib;
  logic       m_legal, m_minus, m_blank;
  logic [3:0] m_nib;

  seg7_inv_decode u_dec_sgn (
    .seg(seg_q), .legal(s_legal), .is_minus(s_minus), .is_blank(s_blank), .nibble(s_nib)
  );

  seg7_inv_decode u_dec_mag (
    .seg(seg_q), .legal(m_legal), .is_minus(m_minus), .is_blank(m_blank), .nibble(m_nib)
  );

  logic unused_dec;
  assign unused_dec = ^{s_legal, s_nib, m_minus, m_blank};

  logic       sgn_legal;
  logic [3:0] sgn_val;
  assign sgn_legal = s_minus || s_blank;
  assign sgn_val   = {3'b000, s_minus};

  // Tracker state lives in these structs so checkers can observe it directly.
  trk_t sgn_trk, mag_trk;
  logic commit_sgn, commit_mag;

  assign commit_sgn = trk_commit(sgn_trk, sel_sgn, sgn_legal, sgn_val, STABLE);
  assign commit_mag = trk_commit(mag_trk, sel_mag, m_legal, m_nib, STABLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_trk <= '{state: TRK_IDLE, cand: 4'h0, cnt: '0};
      mag_trk <= '{state: TRK_IDLE, cand: 4'h0, cnt: '0};
      mag     <= 4'h0;
      neg     <= 1'b0;
      upd     <= 1'b0;
    end else begin
      sgn_trk <= trk_next(sgn_trk, sel_sgn, sgn_legal, sgn_val, STABLE);
      mag_trk <= trk_next(mag_trk, sel_mag, m_legal, m_nib, STABLE);
      if (commit_sgn) neg <= sgn_val[0];
      if (commit_mag) mag <= m_nib;
      upd <= (commit_sgn && (sgn_val[0] != neg)) || (commit_mag && (m_nib != mag));
    end
  end

`ifdef SEG_MUX_CAPTURE_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((sel_sgn && !sgn_legal) || (sel_mag && !m_legal)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_mux_capture.sv
// Directed bench for seg_mux_capture: a vector table streamed one sample per
// cycle with a two-cycle-latency expected queue, plus hand-written reset sequences.
module tb_seg_mux_capture;

`ifdef SEG_MUX_CAPTURE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_1     = 7'h79;
  localparam logic [6:0] G_3     = 7'h30;
  localparam logic [6:0] G_5     = 7'h12;
  localparam logic [6:0] G_7     = 7'h78;
  localparam logic [6:0] G_8     = 7'h00;
  localparam logic [6:0] G_A     = 7'h08;
  localparam logic [6:0] G_B     = 7'h03;
  localparam logic [6:0] G_BAD   = 7'h2A;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg_in;
  logic       an3_in, an4_in;
  logic [3:0] mag;
  logic       neg, upd, err;

  always #5 clk = ~clk;

  seg_mux_capture dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an3_in(an3_in), .an4_in(an4_in),
    .mag(mag), .neg(neg), .upd(upd), .err(err)
  );

  typedef struct {
    logic [6:0] seg;
    logic       an3;
    logic       an4;
    logic [3:0] mag;
    logic       neg;
    logic       upd;
    logic       err;  // expected err when the flag is built
  } vec_t;

  vec_t       vecs[$];
  logic [6:0] exp_q[$];  // {mag, neg, upd, err}
  int         checks = 0;
  int         errors = 0;

  // driver tasks
  task automatic drive(input logic [6:0] s, input logic a3, input logic a4);
    seg_in = s;
    an3_in = a3;
    an4_in = a4;
  endtask

  task automatic add(input logic [6:0] s, input logic a3, input logic a4,
                     input logic [3:0] m, input logic n, input logic u, input logic e);
    vec_t v;
    v = '{seg: s, an3: a3, an4: a4, mag: m, neg: n, upd: u, err: e};
    vecs.push_back(v);
  endtask

  task automatic addm(input logic [6:0] s, input logic [3:0] m, input logic n,
                      input logic u, input logic e);
    add(s, 1'b1, 1'b0, m, n, u, e);
  endtask

  task automatic adds(input logic [6:0] s, input logic [3:0] m, input logic n,
                      input logic u, input logic e);
    add(s, 1'b0, 1'b1, m, n, u, e);
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] e);
    chk({tag, ".mag"}, mag, e[6:3]);
    chk({tag, ".neg"}, 4'(neg), 4'(e[2]));
    chk({tag, ".upd"}, 4'(upd), 4'(e[1]));
    chk({tag, ".err"}, 4'(err), 4'(e[0]));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    drive(G_BLANK, 1'b1, 1'b1);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    logic [6:0] e;

    // Alternating sign "-" and magnitude "5", eight selections each.
    for (int k = 0; k < 8; k++) begin
      adds(G_DASH, (k >= 4) ? 4'h5 : 4'h0, (k >= 3), (k == 3), 1'b0);
      addm(G_5,    (k >= 3) ? 4'h5 : 4'h0, (k >= 3), (k == 3), 1'b0);
    end
    // "3" three times is not enough; the fourth consecutive "b" commits.
    for (int k = 0; k < 3; k++) addm(G_3, 4'h5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) addm(G_B, 4'h5, 1'b1, 1'b0, 1'b0);
    addm(G_B, 4'hB, 1'b1, 1'b1, 1'b0);
    // Both anodes low (with garbage segments) between matching samples.
    for (int k = 0; k < 2; k++) addm(G_7, 4'hB, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) add(G_BAD, 1'b0, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0);
    addm(G_7, 4'hB, 1'b1, 1'b0, 1'b0);
    addm(G_7, 4'h7, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) add(G_BAD, 1'b1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    // Recommitting the same value gives no pulse.
    for (int k = 0; k < 3; k++) addm(G_7, 4'h7, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) addm(G_8, 4'h7, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) addm(G_7, 4'h7, 1'b1, 1'b0, 1'b0);
    // Blank sign digit commits positive.
    for (int k = 0; k < 3; k++) adds(G_BLANK, 4'h7, 1'b1, 1'b0, 1'b0);
    adds(G_BLANK, 4'h7, 1'b0, 1'b1, 1'b0);
    // Illegal magnitude resets the tracker; illegal sign as well.
    for (int k = 0; k < 3; k++) addm(G_1, 4'h7, 1'b0, 1'b0, 1'b0);
    addm(G_BAD, 4'h7, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) addm(G_1, 4'h7, 1'b0, 1'b0, 1'b1);
    addm(G_1, 4'h1, 1'b0, 1'b1, 1'b1);
    adds(G_5, 4'h1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) adds(G_DASH, 4'h1, 1'b0, 1'b0, 1'b1);
    adds(G_DASH, 4'h1, 1'b1, 1'b1, 1'b1);

    // Reset: 20 ns pulse, anodes idle, outputs held at zero.
    rst = 1'b1;
    drive(G_BLANK, 1'b1, 1'b1);
    #20;
    @(negedge clk);
    chk_all("reset_active", 7'h00);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_all($sformatf("reset_idle[%0d]", k), 7'h00);
    end

    // Stream the table; outputs for row i appear two negedges after it is driven.
    for (int i = 0; i < vecs.size() + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = exp_q.pop_front();
        chk_all($sformatf("vec[%0d]", i - 2), e);
      end
      if (i < vecs.size()) begin
        v = vecs[i];
        drive(v.seg, v.an3, v.an4);
        exp_q.push_back({v.mag, v.neg, v.upd, v.err & ERR_EN});
      end else begin
        drive(G_BLANK, 1'b1, 1'b1);
      end
    end

    // Reset mid-track: three "A" samples, reset, then one more "A".
    do_reset(2);
    chk_all("rst2", 7'h00);
    for (int k = 0; k < 3; k++) begin
      drive(G_A, 1'b1, 1'b0);
      @(negedge clk);
      chk_all($sformatf("a_track[%0d]", k), 7'h00);
    end
    drive(G_BLANK, 1'b1, 1'b1);
    @(negedge clk);
    chk_all("a_track_end", 7'h00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(G_A, 1'b1, 1'b0);
    @(negedge clk);
    drive(G_BLANK, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_all($sformatf("after_rst[%0d]", k), 7'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
